// File: rtl/ee457_wbuf.sv
// ee457_wbuf: posted-write buffer between the CPU MEM stage and data memory.
// Stores are queued in a circular FIFO and retired over a valid/ready port.
// Loads read memory combinationally. Define EE457_WBUF_FWD_EN to forward
// pending store data to matching loads (youngest entry wins).
module ee457_wbuf #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [AW-1:0]          cpu_addr,
   input  logic [DW-1:0]          cpu_wdata,
   input  logic                   cpu_read,
   input  logic                   cpu_write,
   output logic [DW-1:0]          cpu_rdata,
   output logic                   wbuf_full,
   output logic                   wbuf_empty,
   output logic [$clog2(DEPTH):0] wbuf_count,
   output logic                   overflow,
   output logic                   mem_wvalid,
   input  logic                   mem_wready,
   output logic [AW-1:0]          mem_waddr,
   output logic [DW-1:0]          mem_wdata,
   output logic [AW-1:0]          mem_raddr,
   input  logic [DW-1:0]          mem_rdata
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-3:0] r_addr [DEPTH];
   logic [DW-1:0] r_data [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          r_ovf;

   logic          w_full;
   logic          w_empty;
   logic          w_drain;
   logic          w_push;
   logic [DW-1:0] w_rdata;
   logic          w_unused;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_drain = !w_empty && mem_wready;
   // A full buffer still accepts a store when the head retires on the same edge.
   assign w_push  = cpu_write && (!w_full || w_drain);

   // Pointer, occupancy and sticky overflow state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push)
            r_tail <= r_tail + PW'(1);
         if (w_drain)
            r_head <= r_head + PW'(1);
         if (w_push && !w_drain)
            r_count <= r_count + CW'(1);
         else if (!w_push && w_drain)
            r_count <= r_count - CW'(1);
         if (cpu_write && !w_push)
            r_ovf <= 1'b1;
      end
   end

   // Entry payload; contents are meaningless outside the valid window, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= cpu_addr[AW-1:2];
         r_data[r_tail] <= cpu_wdata;
      end
   end

`ifdef EE457_WBUF_FWD_EN
   logic [PW-1:0] w_idx;

   // Walk entries oldest to youngest so the last match (youngest) wins.
   // The head entry still matches in the cycle it retires.
   always_comb begin
      w_rdata = mem_rdata;
      w_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_head + PW'(i);
         if ((CW'(i) < r_count) && (r_addr[w_idx] == cpu_addr[AW-1:2]))
            w_rdata = r_data[w_idx];
      end
   end
`else
   assign w_rdata = mem_rdata;
`endif

   assign cpu_rdata  = w_rdata;
   assign mem_raddr  = cpu_addr;
   assign mem_wvalid = !w_empty;
   assign mem_waddr  = {r_addr[r_head], 2'b00};
   assign mem_wdata  = r_data[r_head];
   assign wbuf_full  = w_full;
   assign wbuf_empty = w_empty;
   assign wbuf_count = r_count;
   assign overflow   = r_ovf;

   // Load strobe and byte offset carry no information for a word-granular buffer.
   assign w_unused = ^{cpu_read, cpu_addr[1:0]};

endmodule

// File: doc/ee457_wbuf.md
# ee457_wbuf

Posted-write buffer between the pipelined CPU's data-memory port (MEM stage) and the backing data memory. Stores issued by the MEM stage enter a FIFO and retire to memory through a valid/ready handshake, so a slow memory write port never blocks the store. Loads read the backing memory combinationally, with store-to-load forwarding from pending buffer entries. `wbuf_full` goes to the hazard/stall logic.

## Interface
Parameters:
- `DEPTH`, 4: number of buffer entries. Power of two, ≥2.
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cpu_addr` in AW: byte address from the MEM stage. Bits [1:0] are ignored; the block is word-granular.
- `cpu_wdata` in DW: store data.
- `cpu_read` in 1: load request this cycle.
- `cpu_write` in 1: store request this cycle.
- `cpu_rdata` out DW: load data, combinational, same cycle.
- `wbuf_full` out 1: count == DEPTH.
- `wbuf_empty` out 1: count == 0.
- `wbuf_count` out $clog2(DEPTH)+1: number of valid entries.
- `overflow` out 1: sticky. Set when a store is dropped.
- `mem_wvalid` out 1: head entry is presented to memory.
- `mem_wready` in 1: memory accepts the head entry.
- `mem_waddr` out AW: head entry address.
- `mem_wdata` out DW: head entry data.
- `mem_raddr` out AW: equals `cpu_addr`; drives the asynchronous read port.
- `mem_rdata` in DW: backing memory read data.

## Operation
Storage:
- Circular FIFO with head pointer, tail pointer and count.
- Each entry holds address [AW-1:2] and data.

Drain:
- `mem_wvalid` = !wbuf_empty.
- `mem_waddr` / `mem_wdata` come from the head entry.
- When `mem_wvalid && mem_wready` at a clock edge, head advances and count decrements.
- Entries retire strictly in FIFO order.

Push:
- A store (`cpu_write`=1) is accepted if count < DEPTH, or if a drain occurs in the same cycle.
- On accept, write to the tail entry and advance the tail.
- Count change per edge: +1 for push only, −1 for drain only, 0 for both.
- If the buffer is full and no drain occurs, the store is dropped and `overflow` is set. `overflow` stays high until reset.

Load:
- `cpu_rdata` = data of the youngest valid entry whose address [AW-1:2] matches `cpu_addr`[AW-1:2]; otherwise `mem_rdata`.
- The entry being drained in the current cycle still counts as valid for matching.

Simultaneous events:
- `cpu_read` and `cpu_write` together: the store is pushed at the edge. `cpu_rdata` reflects the state before that edge, so it does not include the new store.
- Pointers wrap modulo DEPTH.

Reset:
- When `rst`=0: head = tail = count = 0 and `overflow` = 0.
- Output values during reset: `wbuf_empty`=1, `wbuf_full`=0, `mem_wvalid`=0.
- Entry contents are don't-care.
- Reset asserted mid-drain discards all pending stores. No `mem_wvalid` appears until a new store arrives.

## Timing
- Store to `mem_wvalid`: a store pushed into an empty buffer at edge N presents `mem_wvalid`=1 in cycle N+1.
- Throughput: one retire per cycle while `mem_wready`=1.
- Ready/valid rules: `mem_wvalid` never deasserts without a handshake except on reset. `mem_waddr`/`mem_wdata` stay stable while `mem_wvalid` && !`mem_wready`.
- `cpu_rdata` has zero-cycle latency: combinational from `cpu_addr`, entry state and `mem_rdata`.
- `wbuf_full`, `wbuf_empty`, `wbuf_count` and `overflow` are registered-state derived, with no combinational path from the `cpu_*` inputs.

## Configuration
`EE457_WBUF_FWD_EN`:
- Defined: store-to-load forwarding as described in Operation.
- Undefined: `cpu_rdata` = `mem_rdata` always. The compare logic is removed. A load that matches a pending entry returns stale memory data; the stall logic must drain the buffer before issuing such a load.

## Test plan
- Reset: `rst` low for 2 cycles, then high → count=0, `wbuf_empty`=1, `mem_wvalid`=0, `overflow`=0.
- Post and drain: store 0x11111111 to 0x100 with `mem_wready`=0 → `mem_wvalid`=1 and `mem_waddr`=0x100 held for 3 cycles. Raise `mem_wready` → entry retires in 1 cycle, `wbuf_empty`=1.
- Forwarding (macro defined):
  - Store 0xAAAA0001 then 0xAAAA0002 to 0x200 with `mem_wready`=0.
  - Load 0x202 → `cpu_rdata`=0xAAAA0002 (youngest match; bits [1:0] ignored).
  - Load 0x300 with `mem_rdata`=0x5 → `cpu_rdata`=0x5.
- Full and overflow (DEPTH=4, `mem_wready`=0):
  - 4 stores → `wbuf_full`=1.
  - 5th store → dropped, `overflow`=1, count stays 4.
  - Raise `mem_wready` while storing → push and drain in the same cycle, count stays 4.
- Wrap-around: 10 stores with `mem_wready` toggling pseudo-randomly → memory receives all 10 in order with correct address/data, and `overflow`=0 whenever the store rate never overruns.
- Reset mid-operation: 3 pending entries, pull `rst` low asynchronously between edges → `mem_wvalid` falls immediately and count=0, with no retire after release.
